// File: rtl/dm_arb_pkg.sv
// Shared constants for the Data_Memory arbiter: FSM state encodings and
// port-select values, plus the word-alignment test used by the arbiter.
package dm_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DMA = 1'b1;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// Saturating counter of consecutive dma arbitration losses; sat tells the
// arbiter that dma must win the next arbitration it takes part in.
module dm_arb_starve_ctr #(
    parameter int LIMIT = 4,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          sat
);

    assign sat = (cnt == CW'(LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one Data_Memory between the pipeline MEM stage (cpu) and a loader/debug
// DMA (dma). Each access runs IDLE -> ACCESS -> RESP, so one access per 3 cycles.
module data_mem_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DW           = 32,
    parameter int AW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_err,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic          dma_err,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_writedata,
    output logic          mem_memwrite,
    output logic          mem_memread,
    input  logic [DW-1:0] mem_readdata,
    output logic [1:0]    dbg_state,
    output logic [3:0]    dbg_starve_cnt
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    // Handshake: a requester raises req with we/addr/wdata and holds them all
    // stable until it sees its one-cycle ack; it may drop or change req in the
    // cycle after ack. req is only sampled in IDLE, never during ACCESS/RESP.

    logic [1:0]    state;
    logic          sel;
    logic          lat_we;
    logic          lat_bad;
    logic [CW-1:0] starve_cnt;
    logic          starve_sat;

    logic          arb;
    logic          dma_win;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_bad;

    always_comb begin
        arb     = (state == IDLE) && (cpu_req || dma_req);
        dma_win = dma_req && (!cpu_req || starve_sat);
        w_we    = dma_win ? dma_we    : cpu_we;
        w_addr  = dma_win ? dma_addr  : cpu_addr;
        w_wdata = dma_win ? dma_wdata : cpu_wdata;
        w_bad   = is_misaligned(w_addr[1:0]);
    end

    dm_arb_starve_ctr #(.LIMIT(STARVE_LIMIT), .CW(CW)) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (arb && !dma_win && dma_req),
        .clr (arb && dma_win),
        .cnt (starve_cnt),
        .sat (starve_sat)
    );

    assign cpu_stall      = cpu_req && !cpu_ack;
    assign dbg_state      = state;
    assign dbg_starve_cnt = 4'(starve_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sel           <= SEL_CPU;
            lat_we        <= 1'b0;
            lat_bad       <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            mem_memwrite  <= 1'b0;
            mem_memread   <= 1'b0;
            cpu_ack       <= 1'b0;
            cpu_err       <= 1'b0;
            cpu_rdata     <= '0;
            dma_ack       <= 1'b0;
            dma_err       <= 1'b0;
            dma_rdata     <= '0;
        end else begin
            cpu_ack <= 1'b0;
            cpu_err <= 1'b0;
            dma_ack <= 1'b0;
            dma_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb) begin
                        sel           <= dma_win ? SEL_DMA : SEL_CPU;
                        lat_we        <= w_we;
                        lat_bad       <= w_bad;
                        mem_address   <= w_addr;
                        mem_writedata <= w_wdata;
                        // A misaligned access still walks the FSM but never touches memory.
                        mem_memwrite  <= w_we && !w_bad;
                        mem_memread   <= !w_we && !w_bad;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_memwrite <= 1'b0;
                    mem_memread  <= 1'b0;
                    state        <= RESP;
                    if (sel == SEL_DMA) begin
                        dma_ack <= 1'b1;
                        dma_err <= lat_bad;
                        if (!lat_we && !lat_bad) dma_rdata <= mem_readdata;
                    end else begin
                        cpu_ack <= 1'b1;
                        cpu_err <= lat_bad;
                        if (!lat_we && !lat_bad) cpu_rdata <= mem_readdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter with a behavioural Data_Memory: directed vector
// table, multi-cycle corner sequences, then randomized traffic vs a reference model.
module tb_data_mem_arbiter;
    import dm_arb_pkg::*;

    localparam int LIMIT = 4;

    logic        clk, rst;
    logic        cpu_req, cpu_we, cpu_ack, cpu_err, cpu_stall;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack, dma_err;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_memwrite, mem_memread;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_starve_cnt;

    data_mem_arbiter #(.DW(32), .AW(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_readdata(mem_readdata),
        .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // Data_Memory stand-in: combinational read, write on rising edge.
    logic [31:0] mem [0:63];
    assign mem_readdata = mem[mem_address[7:2]];
    always @(posedge clk) if (mem_memwrite) mem[mem_address[7:2]] <= mem_writedata;

    // Reference model state
    logic [31:0] ref_mem [0:63];
    logic [31:0] m_rd [0:1];
    int          m_starve;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs [0:7];

    initial clk = 1'b0;
    always #20 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (cpu_ack && dma_ack) begin
                n_fail++;
                $display("FAIL ack_exclusive: cpu_ack=%0b dma_ack=%0b required not both", cpu_ack, dma_ack);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_port(input logic p, input logic r, input logic we,
                              input logic [31:0] a, input logic [31:0] d);
        if (p == SEL_CPU) begin
            cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end else begin
            dma_req = r; dma_we = we; dma_addr = a; dma_wdata = d;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, {30'd0, cpu_ack, cpu_err}, 32'd0);
        check({name, "_dctl"}, {28'd0, dma_ack, dma_err, mem_memwrite, mem_memread}, 32'd0);
        check({name, "_addr"}, mem_address, 32'd0);
        check({name, "_wdata"}, mem_writedata, 32'd0);
        check({name, "_crd"}, cpu_rdata, 32'd0);
        check({name, "_drd"}, dma_rdata, 32'd0);
        check({name, "_state"}, {30'd0, dbg_state}, 32'd0);
    endtask

    // Single access from one port with the other idle.
    task automatic run_vec(input vec_t v, input string name);
        int   lat, wc, rc;
        logic got, other, err;
        logic [31:0] rd;
        @(negedge clk);
        drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        #1;
        if (v.port == SEL_CPU) check({name, "_stall_pre"}, {31'd0, cpu_stall}, 32'd1);
        lat = 0; wc = 0; rc = 0; got = 1'b0; other = 1'b0;
        while (!got && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            wc += int'(mem_memwrite);
            rc += int'(mem_memread);
            got   = (v.port == SEL_CPU) ? cpu_ack : dma_ack;
            other = other | ((v.port == SEL_CPU) ? dma_ack : cpu_ack);
            if (!got && v.port == SEL_CPU) check({name, "_stall"}, {31'd0, cpu_stall}, 32'd1);
        end
        err = (v.port == SEL_CPU) ? cpu_err : dma_err;
        rd  = (v.port == SEL_CPU) ? cpu_rdata : dma_rdata;
        check({name, "_lat"}, lat, 2);
        check({name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
        check({name, "_rdata"}, rd, v.exp_rdata);
        check({name, "_wr_cycles"}, wc, (v.we && v.addr[1:0] == 2'b00) ? 1 : 0);
        check({name, "_rd_cycles"}, rc, (!v.we && v.addr[1:0] == 2'b00) ? 1 : 0);
        check({name, "_other_ack"}, {31'd0, other}, 32'd0);
        if (v.port == SEL_CPU) check({name, "_stall_ack"}, {31'd0, cpu_stall}, 32'd0);
        drive_port(v.port, 1'b0, v.we, v.addr, v.wdata);
        if (v.we && v.addr[1:0] == 2'b00) ref_mem[v.addr[7:2]] = v.wdata;
        m_rd[v.port] = v.exp_rdata;
    endtask

    // Random phase state, per port
    logic        pend [0:1];
    logic        p_we [0:1];
    logic [31:0] p_addr [0:1];
    logic [31:0] p_wd [0:1];

    task automatic new_req(input int p);
        logic [7:0] a;
        pend[p] = ($urandom_range(0, 3) != 0);
        p_we[p] = 1'($urandom_range(0, 1));
        a = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        p_addr[p] = {24'd0, a};
        p_wd[p] = $urandom;
    endtask

    initial begin
        int cpu_at, dma_at, cpu_wins, w, lat;
        int wins[$];
        int exp_w[$];
        logic got_c, got_d, e_err;
        logic [31:0] e_rd;

        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'h1000_0000 + 32'(i);
            ref_mem[i] = 32'h1000_0000 + 32'(i);
        end
        m_rd[0] = '0; m_rd[1] = '0; m_starve = 0;
        rst = 1'b1;
        drive_port(SEL_CPU, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_port(SEL_DMA, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_starve", {28'd0, dbg_starve_cnt}, 32'd0);
        rst = 1'b0;

        vecs[0] = '{SEL_CPU, 1'b1, 32'h14, 32'hf14, 1'b0, 32'h0};
        vecs[1] = '{SEL_CPU, 1'b0, 32'h14, 32'h0,   1'b0, 32'hf14};
        vecs[2] = '{SEL_DMA, 1'b1, 32'h18, 32'h5,   1'b0, 32'h0};
        vecs[3] = '{SEL_DMA, 1'b0, 32'h18, 32'h0,   1'b0, 32'h5};
        vecs[4] = '{SEL_DMA, 1'b1, 32'h16, 32'hbad, 1'b1, 32'h5};
        vecs[5] = '{SEL_CPU, 1'b0, 32'h16, 32'h0,   1'b1, 32'hf14};
        vecs[6] = '{SEL_CPU, 1'b0, 32'h18, 32'h0,   1'b0, 32'h5};
        vecs[7] = '{SEL_DMA, 1'b0, 32'h14, 32'h0,   1'b0, 32'hf14};
        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Simultaneous requests: cpu first, dma three cycles later.
        @(negedge clk);
        drive_port(SEL_CPU, 1'b1, 1'b0, 32'h14, 32'h0);
        drive_port(SEL_DMA, 1'b1, 1'b1, 32'h18, 32'ha);
        cpu_at = 0; dma_at = 0;
        for (int k = 1; k <= 12 && (cpu_at == 0 || dma_at == 0); k++) begin
            @(posedge clk); @(negedge clk);
            if (cpu_ack && cpu_at == 0) begin
                cpu_at = k;
                check("simul_cpu_rdata", cpu_rdata, 32'hf14);
                cpu_req = 1'b0;
            end
            if (dma_ack && dma_at == 0) begin
                dma_at = k;
                check("simul_dma_err", {31'd0, dma_err}, 32'd0);
                dma_req = 1'b0;
            end
        end
        check("simul_cpu_cycle", cpu_at, 2);
        check("simul_dma_cycle", dma_at, 5);
        ref_mem[6] = 32'ha;
        run_vec('{SEL_CPU, 1'b0, 32'h18, 32'h0, 1'b0, 32'ha}, "simul_rd18");

        // Starvation: both held, dma must win the 5th arbitration.
        @(negedge clk);
        drive_port(SEL_CPU, 1'b1, 1'b0, 32'h14, 32'h0);
        drive_port(SEL_DMA, 1'b1, 1'b0, 32'h18, 32'h0);
        exp_w = '{0, 0, 0, 0, 1, 0};
        cpu_wins = 0;
        for (int k = 0; k < 40 && wins.size() < 6; k++) begin
            @(posedge clk); @(negedge clk);
            if (cpu_ack) begin
                wins.push_back(0);
                cpu_wins++;
                check("starve_cpu_rdata", cpu_rdata, 32'hf14);
                if (wins.size() <= 4) check("starve_cnt_inc", {28'd0, dbg_starve_cnt}, cpu_wins);
                if (wins.size() == 6) cpu_req = 1'b0;
            end
            if (dma_ack) begin
                wins.push_back(1);
                check("starve_dma_rdata", dma_rdata, 32'ha);
                check("starve_cnt_clr", {28'd0, dbg_starve_cnt}, 32'd0);
                dma_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        check("starve_n_acks", wins.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("starve_win%0d", i), (i < wins.size()) ? wins[i] : 99, exp_w[i]);
        @(negedge clk);
        check("starve_cnt_end", {28'd0, dbg_starve_cnt}, 32'd0);

        // Reset during the ACCESS cycle of a cpu write.
        @(negedge clk);
        drive_port(SEL_CPU, 1'b1, 1'b1, 32'h14, 32'h9e);
        @(posedge clk); @(negedge clk);
        check("rstmid_write_on", {31'd0, mem_memwrite}, 32'd1);
        check("rstmid_state", {30'd0, dbg_state}, {30'd0, ACCESS});
        #5 rst = 1'b1; cpu_req = 1'b0;
        #1 check_all_zero("rstmid");
        check("rstmid_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            check("rstmid_no_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
        end
        check("rstmid_idle", {30'd0, dbg_state}, {30'd0, IDLE});
        m_rd[0] = '0; m_rd[1] = '0; m_starve = 0;
        run_vec('{SEL_CPU, 1'b0, 32'h14, 32'h0, 1'b0, 32'hf14}, "rstmid_rd14");

        // Idle with no requests.
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); @(negedge clk);
            check("idle_quiet", {28'd0, mem_memread, mem_memwrite, cpu_ack, dma_ack}, 32'd0);
        end

        // Randomized traffic vs reference model.
        new_req(0); new_req(1);
        for (int it = 0; it < 150; it++) begin
            drive_port(SEL_CPU, pend[0], p_we[0], p_addr[0], p_wd[0]);
            drive_port(SEL_DMA, pend[1], p_we[1], p_addr[1], p_wd[1]);
            if (!pend[0] && !pend[1]) begin
                @(posedge clk); @(negedge clk);
                check("rnd_idle", {30'd0, cpu_ack, dma_ack}, 32'd0);
                new_req(0); new_req(1);
                continue;
            end
            w = (pend[1] && (!pend[0] || m_starve == LIMIT)) ? 1 : 0;
            if (w == 1) m_starve = 0;
            else if (pend[1] && m_starve < LIMIT) m_starve++;
            e_err = (p_addr[w][1:0] != 2'b00);
            if (!e_err && !p_we[w]) m_rd[w] = ref_mem[p_addr[w][7:2]];
            if (!e_err && p_we[w]) ref_mem[p_addr[w][7:2]] = p_wd[w];
            e_rd = m_rd[w];
            lat = 0; got_c = 1'b0; got_d = 1'b0;
            while (!got_c && !got_d && lat < 10) begin
                @(posedge clk); lat++; @(negedge clk);
                got_c = cpu_ack; got_d = dma_ack;
            end
            check("rnd_lat", lat, 2);
            check("rnd_winner", {30'd0, got_d, got_c}, (w == 1) ? 32'd2 : 32'd1);
            check("rnd_err", {31'd0, (w == 1) ? dma_err : cpu_err}, {31'd0, e_err});
            check("rnd_rdata", (w == 1) ? dma_rdata : cpu_rdata, e_rd);
            check("rnd_starve", {28'd0, dbg_starve_cnt}, m_starve);
            pend[w] = 1'b0;
            drive_port(w[0], 1'b0, p_we[w], p_addr[w], p_wd[w]);
            @(posedge clk); @(negedge clk);
            new_req(w);
        end
        drive_port(SEL_CPU, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_port(SEL_DMA, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
